// File: rtl/repeat_pattern_checker.sv
// Serial checker for the repeated-pattern stream: compares each valid bit against the
// configured pattern (MSB-first per repetition). Optional macro CHECKER_ABORT_EN ends the run on the first mismatch.
module repeat_pattern_checker #(
   parameter int PAT_W  = 4,
   parameter int SIZE_W = 3,
   parameter int CNT_W  = 7,
   parameter int IDX_W  = 9
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic [PAT_W-1:0]  i_pattern,
   input  logic [SIZE_W-1:0] i_pattern_size,
   input  logic [CNT_W-1:0]  i_times_repeat,
   input  logic              i_bit_valid,
   input  logic              i_bit_in,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_match,
   output logic              o_cfg_err,
   output logic [CNT_W-1:0]  o_reps_ok,
   output logic [IDX_W-1:0]  o_err_idx
);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_FIN} state_t;

   localparam logic [SIZE_W:0] LP_PAT_MAX = (SIZE_W+1)'(PAT_W);

   state_t             r_state;
   logic [PAT_W-1:0]   r_pat;
   logic [SIZE_W-1:0]  r_size;
   logic [CNT_W-1:0]   r_times;
   logic [SIZE_W-1:0]  r_bit_idx;
   logic [CNT_W-1:0]   r_rep_cnt;
   logic [IDX_W-1:0]   r_sidx;
   logic               r_mis;
   logic [CNT_W-1:0]   r_reps_int;
   logic [IDX_W-1:0]   r_err_int;
   logic               r_busy;
   logic               r_done;
   logic               r_match;
   logic               r_cfg_err;
   logic [CNT_W-1:0]   r_reps_ok;
   logic [IDX_W-1:0]   r_err_idx;

   logic [PAT_W-1:0]   w_shift;
   logic               w_bad;
   logic               w_wrap;
   logic               w_last;
   logic               w_first_bad;
   logic               w_abort;
   logic               w_size_bad;
   logic [CNT_W-1:0]   w_reps_nxt;
   logic [IDX_W-1:0]   w_err_nxt;

   assign w_shift     = r_pat >> r_bit_idx;
   assign w_bad       = i_bit_in != w_shift[0];
   assign w_wrap      = r_bit_idx == '0;
   assign w_last      = w_wrap && (r_rep_cnt == r_times - CNT_W'(1));
   assign w_first_bad = !r_mis && w_bad;
   assign w_size_bad  = (i_pattern_size == '0) || ({1'b0, i_pattern_size} > LP_PAT_MAX);

`ifdef CHECKER_ABORT_EN
   assign w_abort = w_first_bad;
`else
   assign w_abort = 1'b0;
`endif

   // reps_ok freezes at the repetition holding the first error; a bad bit never completes a clean rep
   always_comb begin
      w_reps_nxt = r_reps_int;
      w_err_nxt  = r_err_int;
      if (w_first_bad) begin
         w_reps_nxt = r_rep_cnt;
         w_err_nxt  = r_sidx;
      end else if (!r_mis && w_wrap) begin
         w_reps_nxt = r_rep_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_pat      <= '0;
         r_size     <= '0;
         r_times    <= '0;
         r_bit_idx  <= '0;
         r_rep_cnt  <= '0;
         r_sidx     <= '0;
         r_mis      <= 1'b0;
         r_reps_int <= '0;
         r_err_int  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_match    <= 1'b0;
         r_cfg_err  <= 1'b0;
         r_reps_ok  <= '0;
         r_err_idx  <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_pat     <= i_pattern;
                  r_size    <= i_pattern_size;
                  r_times   <= i_times_repeat;
                  r_reps_ok <= '0;
                  r_err_idx <= '0;
                  if (w_size_bad) begin
                     r_state   <= S_FIN;
                     r_done    <= 1'b1;
                     r_cfg_err <= 1'b1;
                     r_match   <= 1'b0;
                  end else if (i_times_repeat == '0) begin
                     r_state   <= S_FIN;
                     r_done    <= 1'b1;
                     r_cfg_err <= 1'b0;
                     r_match   <= 1'b1;
                  end else begin
                     r_state    <= S_CHECK;
                     r_busy     <= 1'b1;
                     r_cfg_err  <= 1'b0;
                     r_match    <= 1'b0;
                     r_bit_idx  <= i_pattern_size - SIZE_W'(1);
                     r_rep_cnt  <= '0;
                     r_sidx     <= '0;
                     r_mis      <= 1'b0;
                     r_reps_int <= '0;
                     r_err_int  <= '0;
                  end
               end
            end
            S_CHECK: begin
               if (i_bit_valid) begin
                  r_mis      <= r_mis | w_bad;
                  r_reps_int <= w_reps_nxt;
                  r_err_int  <= w_err_nxt;
                  if (r_sidx != '1)
                     r_sidx <= r_sidx + IDX_W'(1);
                  if (w_wrap) begin
                     r_bit_idx <= r_size - SIZE_W'(1);
                     r_rep_cnt <= r_rep_cnt + CNT_W'(1);
                  end else begin
                     r_bit_idx <= r_bit_idx - SIZE_W'(1);
                  end
                  if (w_last || w_abort) begin
                     r_state   <= S_FIN;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                     r_match   <= !(r_mis | w_bad);
                     r_reps_ok <= w_reps_nxt;
                     r_err_idx <= w_err_nxt;
                  end
               end
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_match   = r_match;
   assign o_cfg_err = r_cfg_err;
   assign o_reps_ok = r_reps_ok;
   assign o_err_idx = r_err_idx;

endmodule

// File: tb/tb_repeat_pattern_checker.sv
// Directed bench for repeat_pattern_checker: config-response table plus hand-written stream runs.
module tb_repeat_pattern_checker;

   logic       i_clk = 1'b0;
   logic       i_rst_n;
   logic       i_start;
   logic [3:0] i_pattern;
   logic [2:0] i_pattern_size;
   logic [6:0] i_times_repeat;
   logic       i_bit_valid;
   logic       i_bit_in;
   logic       o_busy;
   logic       o_done;
   logic       o_match;
   logic       o_cfg_err;
   logic [6:0] o_reps_ok;
   logic [8:0] o_err_idx;

   int n_chk = 0;
   int n_bad = 0;

   repeat_pattern_checker dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_start        (i_start),
      .i_pattern      (i_pattern),
      .i_pattern_size (i_pattern_size),
      .i_times_repeat (i_times_repeat),
      .i_bit_valid    (i_bit_valid),
      .i_bit_in       (i_bit_in),
      .o_busy         (o_busy),
      .o_done         (o_done),
      .o_match        (o_match),
      .o_cfg_err      (o_cfg_err),
      .o_reps_ok      (o_reps_ok),
      .o_err_idx      (o_err_idx)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [3:0] pat;
      logic [2:0] sz;
      logic [6:0] tr;
      logic       exp_cfg;
      logic       exp_match;
   } cfg_vec_t;

   task automatic check(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   // One full run; mid_start >= 0 pulses an illegal start alongside that bit.
   task automatic run(input string nm, input logic [3:0] pat, input logic [2:0] sz,
                      input logic [6:0] tr, input int flip, input bit gaps,
                      input int mid_start, input bit vld_on_start,
                      input bit exp_match, input int exp_reps, input int exp_err);
      int  n;
      int  stop;
      int  bi;
      bit  seen;
      n    = int'(tr) * int'(sz);
      stop = n - 1;
`ifdef CHECKER_ABORT_EN
      if (flip >= 0) stop = flip;
`endif
      i_pattern      = pat;
      i_pattern_size = sz;
      i_times_repeat = tr;
      i_start        = 1'b1;
      i_bit_valid    = vld_on_start;
      i_bit_in       = ~pat[int'(sz) - 1];
      tick();
      i_start     = 1'b0;
      i_bit_valid = 1'b0;
      check({nm, "_busy_rise"}, int'(o_busy), 1);
      check({nm, "_done_start"}, int'(o_done), 0);
      seen = 1'b0;
      for (int k = 0; k <= stop; k++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               tick();
               if (o_done) seen = 1'b1;
            end
         end
         bi          = int'(sz) - 1 - (k % int'(sz));
         i_bit_valid = 1'b1;
         i_bit_in    = pat[bi] ^ (k == flip);
         if (k == mid_start) begin
            i_start        = 1'b1;
            i_pattern_size = 3'd0;
         end
         tick();
         i_start     = 1'b0;
         i_bit_valid = 1'b0;
         if (k < stop && o_done) seen = 1'b1;
      end
      check({nm, "_early_done"}, int'(seen), 0);
      check({nm, "_done"}, int'(o_done), 1);
      check({nm, "_busy_fall"}, int'(o_busy), 0);
      check({nm, "_match"}, int'(o_match), int'(exp_match));
      check({nm, "_cfg_err"}, int'(o_cfg_err), 0);
      check({nm, "_reps_ok"}, int'(o_reps_ok), exp_reps);
      check({nm, "_err_idx"}, int'(o_err_idx), exp_err);
      tick();
      check({nm, "_done_pulse"}, int'(o_done), 0);
      check({nm, "_match_hold"}, int'(o_match), int'(exp_match));
      check({nm, "_reps_hold"}, int'(o_reps_ok), exp_reps);
   endtask

   initial begin
      cfg_vec_t cv[6];
      bit seen;
      int flip_rep;

      cv[0] = '{4'hC, 3'd0, 7'd5, 1'b1, 1'b0};
      cv[1] = '{4'hC, 3'd5, 7'd5, 1'b1, 1'b0};
      cv[2] = '{4'hC, 3'd7, 7'd1, 1'b1, 1'b0};
      cv[3] = '{4'hC, 3'd4, 7'd0, 1'b0, 1'b1};
      cv[4] = '{4'h0, 3'd0, 7'd0, 1'b1, 1'b0};
      cv[5] = '{4'h3, 3'd2, 7'd0, 1'b0, 1'b1};

      i_rst_n = 1'b0; i_start = 1'b0; i_pattern = '0; i_pattern_size = '0;
      i_times_repeat = '0; i_bit_valid = 1'b0; i_bit_in = 1'b0;
      tick(); tick();
      check("rst_busy", int'(o_busy), 0);
      check("rst_done", int'(o_done), 0);
      check("rst_match", int'(o_match), 0);
      check("rst_cfg_err", int'(o_cfg_err), 0);
      check("rst_reps_ok", int'(o_reps_ok), 0);
      check("rst_err_idx", int'(o_err_idx), 0);
      i_rst_n = 1'b1;
      tick();

      // Configurations that finish the cycle after start without a CHECK phase
      for (int i = 0; i < 6; i++) begin
         i_pattern = cv[i].pat; i_pattern_size = cv[i].sz; i_times_repeat = cv[i].tr;
         i_start = 1'b1;
         tick();
         i_start = 1'b0;
         check($sformatf("cfg%0d_done", i), int'(o_done), 1);
         check($sformatf("cfg%0d_busy", i), int'(o_busy), 0);
         check($sformatf("cfg%0d_cfg_err", i), int'(o_cfg_err), int'(cv[i].exp_cfg));
         check($sformatf("cfg%0d_match", i), int'(o_match), int'(cv[i].exp_match));
         check($sformatf("cfg%0d_reps", i), int'(o_reps_ok), 0);
         check($sformatf("cfg%0d_err_idx", i), int'(o_err_idx), 0);
         tick();
         check($sformatf("cfg%0d_done_pulse", i), int'(o_done), 0);
         check($sformatf("cfg%0d_busy_after", i), int'(o_busy), 0);
         check($sformatf("cfg%0d_cfg_hold", i), int'(o_cfg_err), int'(cv[i].exp_cfg));
      end

      run("clean",   4'b1100, 3'd4, 7'd75, -1,  1'b0, -1, 1'b0, 1'b1, 75, 0);
      run("flip10",  4'b1100, 3'd4, 7'd75, 10,  1'b0, -1, 1'b0, 1'b0, 2,  10);
      run("flip0",   4'b1100, 3'd4, 7'd75, 0,   1'b0, -1, 1'b0, 1'b0, 0,  0);
      run("flip299", 4'b1100, 3'd4, 7'd75, 299, 1'b0, -1, 1'b0, 1'b0, 74, 299);
      run("gaps",    4'b0101, 3'd3, 7'd2,  -1,  1'b1, -1, 1'b0, 1'b1, 2,  0);
      flip_rep = 6;
      run("sz1flip", 4'b0001, 3'd1, 7'd9,  flip_rep, 1'b1, -1, 1'b0, 1'b0, 6, 6);
      run("midstart",4'b1001, 3'd4, 7'd3,  -1,  1'b0, 5,  1'b0, 1'b1, 3,  0);
      run("vldstart",4'b1100, 3'd4, 7'd2,  -1,  1'b0, -1, 1'b1, 1'b1, 2,  0);

      // Reset at stream bit 50 abandons the run silently
      i_pattern = 4'b1100; i_pattern_size = 3'd4; i_times_repeat = 7'd75;
      i_start = 1'b1;
      tick();
      i_start = 1'b0;
      for (int k = 0; k < 50; k++) begin
         i_bit_valid = 1'b1;
         i_bit_in    = i_pattern[3 - (k % 4)];
         tick();
      end
      check("rstmid_busy_before", int'(o_busy), 1);
      i_rst_n = 1'b0;
      i_bit_in = i_pattern[3 - (50 % 4)];
      tick();
      i_rst_n = 1'b1;
      check("rstmid_busy", int'(o_busy), 0);
      check("rstmid_done", int'(o_done), 0);
      check("rstmid_match", int'(o_match), 0);
      check("rstmid_cfg_err", int'(o_cfg_err), 0);
      check("rstmid_reps_ok", int'(o_reps_ok), 0);
      check("rstmid_err_idx", int'(o_err_idx), 0);
      seen = 1'b0;
      for (int k = 51; k < 300; k++) begin
         i_bit_in = i_pattern[3 - (k % 4)];
         tick();
         if (o_done || o_busy) seen = 1'b1;
      end
      i_bit_valid = 1'b0;
      tick();
      check("rstmid_no_activity", int'(seen), 0);

      run("fresh",   4'b1100, 3'd4, 7'd75, -1,  1'b0, -1, 1'b0, 1'b1, 75, 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/repeat_pattern_checker.md
# repeat_pattern_checker

Serial receive-side checker for the repeated-pattern stream. Given the same `pattern`, `pattern_size` and `times_repeat` configuration the generator uses, it consumes the stream one bit per valid cycle and compares each bit against the expected pattern bit. It reports pass/fail, the number of clean repetitions before the first error, and the stream index of the first mismatching bit. It sits at the link's far end as the self-check for the repeated-pattern path.

## Interface
- `PAT_W`, 4, maximum pattern width in bits
- `SIZE_W`, 3, width of `pattern_size`
- `CNT_W`, 7, width of `times_repeat` and of the repetition counters
- `IDX_W`, 9, width of the stream bit index; must hold `(2**CNT_W-1)*PAT_W`
- `clk`  in  1  clock; all logic on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse; latches configuration and begins a run
- `pattern`  in  PAT_W  pattern bits, sampled on `start`
- `pattern_size`  in  SIZE_W  active pattern length in bits, sampled on `start`
- `times_repeat`  in  CNT_W  expected repetition count, sampled on `start`
- `bit_valid`  in  1  `bit_in` is valid this cycle
- `bit_in`  in  1  serial stream bit
- `busy`  out  1  high in the CHECK state
- `done`  out  1  one-cycle pulse at the end of a run
- `match`  out  1  run result; valid from `done` until the next `start`
- `cfg_err`  out  1  run rejected because of an illegal `pattern_size`
- `reps_ok`  out  CNT_W  complete repetitions matched before the first error
- `err_idx`  out  IDX_W  stream index (0-based) of the first mismatching bit; 0 when `match`=1

## Operation
- The FSM has three states: IDLE, CHECK, FIN.
- **IDLE, on `start`:** latch the configuration. Then:
  - `pattern_size`==0 or >PAT_W: go to FIN with `cfg_err`=1 and `match`=0.
  - `times_repeat`==0: go to FIN with `match`=1 and `reps_ok`=0.
  - Otherwise: go to CHECK. Clear the counters and the mismatch flag. Set `bit_idx`=`pattern_size`-1.
- **Bit order:** each repetition is sent MSB-first over the active window, i.e. `pattern[pattern_size-1]` down to `pattern[0]`.
- **CHECK, on each `bit_valid`:**
  - Compare `bit_in` against `pattern[bit_idx]`.
  - Increment the stream index `sidx`.
  - Decrement `bit_idx`. At 0 it wraps to `pattern_size`-1 and increments `rep_cnt`.
- **First mismatch:** set the sticky `mis` flag, latch `err_idx`=`sidx`, and freeze `reps_ok` at the current `rep_cnt`.
- **Clean repetition:** while `mis`=0, each completed repetition sets `reps_ok`=`rep_cnt`+1.
- **End of run:** when the last expected bit is accepted (`rep_cnt`==`times_repeat`-1 and `bit_idx`==0), go to FIN.
- **FIN:** lasts exactly one cycle. `done`=1, `match`=!`mis`, then return to IDLE.
- **Ignored inputs:**
  - `start` while in CHECK or FIN.
  - `bit_valid` in IDLE or FIN, including when it coincides with `start`.
- **Widths:** all counters are unsigned. `sidx` saturates at `2**IDX_W-1` and never wraps.

## Timing
- **Reset values:** `busy`=0, `done`=0, `match`=0, `cfg_err`=0, `reps_ok`=0, `err_idx`=0. FSM in IDLE.
- **Reset during CHECK:** the run is abandoned, no `done` is produced, and all outputs return to their reset values the next cycle.
- `busy` rises the cycle after `start` when the run is legal.
- `done` is asserted the cycle after the final bit is accepted. Total latency is N+1 accepted-bit cycles from the first bit, where N = `times_repeat`·`pattern_size`.
- A config error or `times_repeat`==0 produces `done` the cycle after `start`, with `busy` never rising.
- `match`, `cfg_err`, `reps_ok` and `err_idx` update together with `done` and hold until the next accepted `start`.
- A new `start` is accepted in the cycle after `done`.
- `bit_valid` may have arbitrary gaps; the checker never stalls the source.

## Configuration
- Macro: `CHECKER_ABORT_EN`.
- **Defined:** the first mismatch moves the FSM directly to FIN, so `done` is asserted the cycle after the bad bit, and the remaining stream bits are ignored. `err_idx` and `reps_ok` are as described above.
- **Undefined:** the checker consumes all N bits regardless of mismatches.

## Test plan
- **Clean long run:** `pattern`=4'b1100, `pattern_size`=4, `times_repeat`=75, with 300 correct bits on consecutive valid cycles. Expect `done` one cycle after bit 299, `match`=1, `reps_ok`=75, `err_idx`=0.
- **Single flipped bit:** same configuration with bit 10 flipped. Expect `match`=0, `err_idx`=10, `reps_ok`=2.
  - Without the macro: `done` after bit 299.
  - With `CHECKER_ABORT_EN`: `done` the cycle after bit 10.
- **Short pattern with gaps:** `pattern`=4'b0101, `pattern_size`=3 (expected 101), `times_repeat`=2, stream 101101 with random `bit_valid` gaps. Expect `match`=1, `reps_ok`=2.
- **Illegal configuration:**
  - `pattern_size`=0: expect `done` and `cfg_err`=1 the cycle after `start`, and `busy` never rises.
  - `pattern_size`=5: same response.
  - `times_repeat`=0: expect `match`=1.
- **Reset mid-run:** assert `rst_n`=0 for one cycle at stream bit 50 of the 75×4 run. Expect all outputs zero and no `done`. A fresh run then passes.
- **Ignored inputs:** `start` pulsed during CHECK is ignored and the run result is unchanged. `bit_valid` asserted in the same cycle as `start` is not counted.
